// File: rtl/input_cond_pkg.sv
// Shared types and helpers for the multi-channel input conditioner.
// Channel FSM states plus a counter-width helper sized to hold a terminal count.
package input_cond_pkg;

  typedef enum logic [2:0] {
    REL,
    PDEB,
    PRS,
    HLD,
    RDEB
  } ch_state_t;

  localparam int EVT_W = 8;

  function automatic int cnt_w(input int p);
    return $clog2(p + 1);
  endfunction

endpackage

// File: rtl/input_cond_ch.sv
// One conditioned input: metastability chain, polarity fix, debounce FSM,
// and press/release/hold/auto-repeat pulse generation. All outputs registered.
module input_cond_ch
  import input_cond_pkg::*;
#(
  parameter int SYNC_STAGES   = 2,
  parameter int DEB_CYCLES    = 27000,
  parameter int HOLD_CYCLES   = 27000000,
  parameter int REPEAT_CYCLES = 5400000,
  parameter bit ACTIVE_LOW    = 1'b1,
  parameter bit REPEAT_EN     = 1'b0
) (
  input  logic clk27,
  input  logic reset,
  input  logic pin,
  output logic level,
  output logic press_p,
  output logic release_p,
  output logic hold_p,
  output logic repeat_p
);

  localparam int DW = cnt_w(DEB_CYCLES);
  localparam int HW = cnt_w(HOLD_CYCLES);
  localparam int RW = cnt_w(REPEAT_CYCLES);

  localparam logic [DW-1:0] DEB_LAST = DW'(DEB_CYCLES - 1);
  localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_CYCLES - 1);
  localparam logic [RW-1:0] REP_LAST = RW'(REPEAT_CYCLES - 1);

  logic [SYNC_STAGES-1:0] sync_p;
  logic                   s;

  ch_state_t       state;
  logic [DW-1:0]   dcnt;
  logic [HW-1:0]   hcnt;
  logic [RW-1:0]   rcnt;
  logic            held;

  // Synchroniser stage: reset to the idle pin level so s starts released
  always_ff @(posedge clk27 or posedge reset) begin
    if (reset) begin
      sync_p <= {SYNC_STAGES{ACTIVE_LOW}};
    end else begin
      sync_p <= {sync_p[SYNC_STAGES-2:0], pin};
    end
  end

  assign s = sync_p[SYNC_STAGES-1] ^ ACTIVE_LOW;

  // Debounce / hold / repeat stage
  always_ff @(posedge clk27 or posedge reset) begin
    if (reset) begin
      state     <= REL;
      dcnt      <= '0;
      hcnt      <= '0;
      rcnt      <= '0;
      held      <= 1'b0;
      level     <= 1'b0;
      press_p   <= 1'b0;
      release_p <= 1'b0;
      hold_p    <= 1'b0;
      repeat_p  <= 1'b0;
    end else begin
      press_p   <= 1'b0;
      release_p <= 1'b0;
      hold_p    <= 1'b0;
      repeat_p  <= 1'b0;
      case (state)
        REL: begin
          if (s) begin
            state <= PDEB;
            dcnt  <= '0;
          end
        end
        PDEB: begin
          if (!s) begin
            state <= REL;
          end else if (dcnt == DEB_LAST) begin
            state   <= PRS;
            level   <= 1'b1;
            press_p <= 1'b1;
            hcnt    <= '0;
          end else begin
            dcnt <= dcnt + 1'b1;
          end
        end
        PRS: begin
          if (!s) begin
            state <= RDEB;
            held  <= 1'b0;
            dcnt  <= '0;
          end else if (hcnt == HOLD_LAST) begin
            state  <= HLD;
            hold_p <= 1'b1;
            rcnt   <= '0;
          end else begin
            hcnt <= hcnt + 1'b1;
          end
        end
        HLD: begin
          if (!s) begin
            state <= RDEB;
            held  <= 1'b1;
            dcnt  <= '0;
          end else if (REPEAT_EN) begin
            if (rcnt == REP_LAST) begin
              repeat_p <= 1'b1;
              rcnt     <= '0;
            end else begin
              rcnt <= rcnt + 1'b1;
            end
          end
        end
        RDEB: begin
          // A bounce back to pressed resumes hold/repeat timing where it paused
          if (s) begin
            state <= held ? HLD : PRS;
          end else if (dcnt == DEB_LAST) begin
            state     <= REL;
            level     <= 1'b0;
            release_p <= 1'b1;
          end else begin
            dcnt <= dcnt + 1'b1;
          end
        end
        default: state <= REL;
      endcase
    end
  end

endmodule

// File: rtl/input_cond.sv
// Multi-channel input conditioner: CH independent channels plus a shared
// wrapping count of accepted presses across all channels.
module input_cond
  import input_cond_pkg::*;
#(
  parameter int            CH            = 2,
  parameter int            SYNC_STAGES   = 2,
  parameter int            DEB_CYCLES    = 27000,
  parameter int            HOLD_CYCLES   = 27000000,
  parameter int            REPEAT_CYCLES = 5400000,
  parameter logic [CH-1:0] ACTIVE_LOW    = {CH{1'b1}},
  parameter logic [CH-1:0] REPEAT_EN     = {CH{1'b0}}
) (
  input  logic             clk27,
  input  logic             reset,
  input  logic [CH-1:0]    in_raw,
  output logic [CH-1:0]    level,
  output logic [CH-1:0]    press_p,
  output logic [CH-1:0]    release_p,
  output logic [CH-1:0]    hold_p,
  output logic [CH-1:0]    repeat_p,
  output logic [EVT_W-1:0] event_cnt
);

  function automatic logic [EVT_W-1:0] popcount(input logic [CH-1:0] v);
    logic [EVT_W-1:0] n;
    n = '0;
    for (int i = 0; i < CH; i++) begin
      n = n + EVT_W'(v[i]);
    end
    return n;
  endfunction

  for (genvar g = 0; g < CH; g++) begin : g_ch
    input_cond_ch #(
      .SYNC_STAGES  (SYNC_STAGES),
      .DEB_CYCLES   (DEB_CYCLES),
      .HOLD_CYCLES  (HOLD_CYCLES),
      .REPEAT_CYCLES(REPEAT_CYCLES),
      .ACTIVE_LOW   (ACTIVE_LOW[g]),
      .REPEAT_EN    (REPEAT_EN[g])
    ) u_ch (
      .clk27    (clk27),
      .reset    (reset),
      .pin      (in_raw[g]),
      .level    (level[g]),
      .press_p  (press_p[g]),
      .release_p(release_p[g]),
      .hold_p   (hold_p[g]),
      .repeat_p (repeat_p[g])
    );
  end

  // Event count stage: one cycle behind the registered press pulses, wraps mod 256
  always_ff @(posedge clk27 or posedge reset) begin
    if (reset) begin
      event_cnt <= '0;
    end else begin
      event_cnt <= event_cnt + popcount(press_p);
    end
  end

endmodule

// File: tb/tb_input_cond.sv
// Bench for input_cond: table of press scenarios feeding a cycle-stamped
// event scoreboard, plus hand-written wrap and mid-hold reset sequences.
module tb_input_cond;

  localparam int K_PRESS = 0;
  localparam int K_REL   = 1;
  localparam int K_HOLD  = 2;
  localparam int K_REP   = 3;

  logic       clk27 = 1'b0;
  logic       reset = 1'b1;
  logic [1:0] in_raw = 2'b11;
  logic [1:0] level, press_p, release_p, hold_p, repeat_p;
  logic [7:0] event_cnt;

  int cyc = 0;
  int n_vec = 0;
  int n_mis = 0;

  typedef struct {
    int cyc;
    int ch;
    int kind;
  } ev_t;
  ev_t sb[$];

  typedef struct {
    logic [1:0] mask;
    int         len;
    bit         pr;
    bit         hd;
    int         reps;
  } vec_t;
  vec_t tbl[10];

  logic [1:0] exp_level = '0;
  logic [1:0] prev_press = '0;
  logic [7:0] exp_evt = '0;

  input_cond #(
    .CH(2), .SYNC_STAGES(2), .DEB_CYCLES(4), .HOLD_CYCLES(10),
    .REPEAT_CYCLES(3), .ACTIVE_LOW(2'b11), .REPEAT_EN(2'b10)
  ) dut (
    .clk27(clk27), .reset(reset), .in_raw(in_raw), .level(level),
    .press_p(press_p), .release_p(release_p), .hold_p(hold_p),
    .repeat_p(repeat_p), .event_cnt(event_cnt)
  );

  always #5 clk27 = ~clk27;
  always @(posedge clk27) cyc <= cyc + 1;

  // Scoreboard monitor: pops events stamped for this cycle and compares everything
  always @(posedge clk27) begin
    logic [1:0] e_pr, e_rl, e_hd, e_rp;
    #1;
    e_pr = '0; e_rl = '0; e_hd = '0; e_rp = '0;
    for (int i = sb.size() - 1; i >= 0; i--) begin
      if (sb[i].cyc == cyc) begin
        case (sb[i].kind)
          K_PRESS: e_pr[sb[i].ch] = 1'b1;
          K_REL:   e_rl[sb[i].ch] = 1'b1;
          K_HOLD:  e_hd[sb[i].ch] = 1'b1;
          default: e_rp[sb[i].ch] = 1'b1;
        endcase
        sb.delete(i);
      end
    end
    if (reset) begin
      exp_level  = '0;
      exp_evt    = '0;
      prev_press = '0;
      e_pr = '0; e_rl = '0; e_hd = '0; e_rp = '0;
    end else begin
      exp_evt    = exp_evt + 8'(prev_press[0]) + 8'(prev_press[1]);
      exp_level  = (exp_level | e_pr) & ~e_rl;
      prev_press = e_pr;
    end
    n_vec++;
    if (level !== exp_level || press_p !== e_pr || release_p !== e_rl ||
        hold_p !== e_hd || repeat_p !== e_rp || event_cnt !== exp_evt) begin
      n_mis++;
      $display("FAIL cycle %0d: lvl/prs/rel/hld/rep/evt got %b %b %b %b %b %0d want %b %b %b %b %b %0d",
               cyc, level, press_p, release_p, hold_p, repeat_p, event_cnt,
               exp_level, e_pr, e_rl, e_hd, e_rp, exp_evt);
    end
  end

  task automatic check(input string nm, input int act, input int exp);
    n_vec++;
    if (act !== exp) begin
      n_mis++;
      $display("FAIL %s: got %0d want %0d", nm, act, exp);
    end
  endtask

  task automatic push(input int c, input int ch, input int kind);
    ev_t e;
    e.cyc = c; e.ch = ch; e.kind = kind;
    sb.push_back(e);
  endtask

  // Drives the masked channels pressed for len sampling edges, then releases
  task automatic apply(input vec_t v);
    int t0;
    @(negedge clk27);
    t0 = cyc + 1;
    in_raw = ~v.mask;
    for (int c = 0; c < 2; c++) begin
      if (v.mask[c]) begin
        if (v.pr) begin
          push(t0 + 6, c, K_PRESS);
          push(t0 + v.len + 6, c, K_REL);
        end
        if (v.hd) push(t0 + 16, c, K_HOLD);
        if (c == 1) begin
          for (int j = 0; j < v.reps; j++) push(t0 + 19 + 3 * j, c, K_REP);
        end
      end
    end
    repeat (v.len) @(negedge clk27);
    in_raw = 2'b11;
    repeat (12) @(negedge clk27);
  endtask

  task automatic pulse_reset();
    @(negedge clk27);
    reset = 1'b1;
    sb.delete();
    #1;
    check("rst_level", int'(level), 0);
    check("rst_evt", int'(event_cnt), 0);
    check("rst_pulses", int'(press_p | release_p | hold_p | repeat_p), 0);
    repeat (2) @(negedge clk27);
    reset = 1'b0;
  endtask

  initial begin
    vec_t v;
    int   n;
    tbl[0] = '{2'b01, 30, 1'b1, 1'b1, 0};
    tbl[1] = '{2'b01,  3, 1'b0, 1'b0, 0};
    tbl[2] = '{2'b01,  4, 1'b0, 1'b0, 0};
    tbl[3] = '{2'b01,  5, 1'b1, 1'b0, 0};
    tbl[4] = '{2'b10, 14, 1'b1, 1'b0, 0};
    tbl[5] = '{2'b10, 15, 1'b1, 1'b1, 0};
    tbl[6] = '{2'b10, 18, 1'b1, 1'b1, 1};
    tbl[7] = '{2'b10, 36, 1'b1, 1'b1, 7};
    tbl[8] = '{2'b11,  8, 1'b1, 1'b0, 0};
    tbl[9] = '{2'b11, 20, 1'b1, 1'b1, 1};

    repeat (3) @(negedge clk27);
    check("init_level", int'(level), 0);
    check("init_evt", int'(event_cnt), 0);
    reset = 1'b0;
    repeat (2) @(negedge clk27);

    for (int i = 0; i < 10; i++) apply(tbl[i]);
    check("evt_after_table", int'(event_cnt), 10);

    // Counter wrap: 257 clean presses from zero read back as 1
    pulse_reset();
    v = '{2'b01, 5, 1'b1, 1'b0, 0};
    for (int i = 0; i < 257; i++) apply(v);
    check("evt_wrap", int'(event_cnt), 1);

    // Reset while channel 0 sits in HLD with the pin still pressed
    pulse_reset();
    @(negedge clk27);
    n = cyc + 1;
    in_raw = 2'b10;
    push(n + 6, 0, K_PRESS);
    push(n + 16, 0, K_HOLD);
    repeat (20) @(negedge clk27);
    check("hld_evt", int'(event_cnt), 1);
    pulse_reset();
    n = cyc;
    push(n + 7, 0, K_PRESS);
    push(n + 17, 0, K_HOLD);
    repeat (6) @(negedge clk27);
    check("post_rst_no_press_yet", int'(level), 0);
    @(negedge clk27);
    check("post_rst_press", int'(press_p), 1);
    repeat (15) @(negedge clk27);
    check("post_rst_evt", int'(event_cnt), 1);
    n = cyc + 1;
    in_raw = 2'b11;
    push(n + 6, 0, K_REL);
    repeat (12) @(negedge clk27);
    check("post_rst_level", int'(level), 0);

    check("sb_drained", sb.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
    $finish;
  end

endmodule

// File: doc/input_cond.md
# input_cond

Parametrised multi-channel input conditioner on clk27. It generalises the fixed two-flop button/IR/HDMI-status synchronizers of the top level to CH channels, each with configurable synchroniser depth and per-bit polarity. Each channel adds debounce, press/release/hold/auto-repeat pulse generation, and a shared wrapping press-event counter. Its outputs feed the CPU controls PIO, replacing the raw synchronised button bits.

## Interface
- CH, 2, number of input channels (1..16)
- SYNC_STAGES, 2, synchroniser flops per channel (>=2)
- DEB_CYCLES, 27000, cycles a level must be stable to be accepted (>=1; 1 ms at 27 MHz)
- HOLD_CYCLES, 27000000, cycles pressed before hold pulse (>=1)
- REPEAT_CYCLES, 5400000, auto-repeat period after hold (>=1)
- ACTIVE_LOW, {CH{1'b1}}, per-channel polarity; bit=1 means pin low = pressed
- REPEAT_EN, {CH{1'b0}}, per-channel auto-repeat enable
- clk27  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- in_raw  in  CH  asynchronous pins
- level  out  CH  debounced pressed state, 1 = pressed
- press_p  out  CH  one-cycle pulse on accepted press
- release_p  out  CH  one-cycle pulse on accepted release
- hold_p  out  CH  one-cycle pulse when held HOLD_CYCLES
- repeat_p  out  CH  one-cycle pulse every REPEAT_CYCLES while held, if REPEAT_EN
- event_cnt  out  8  total accepted presses, all channels, mod 256

## Operation
- Sync chain reset value = ACTIVE_LOW bit, so the synchronised, polarity-corrected signal s is 0 (released) out of reset.
- Per-channel FSM, reset state REL:
  - REL: s=1 -> PDEB, dcnt=0.
  - PDEB: s=0 -> REL (glitch rejected, no pulse). Otherwise dcnt++. When dcnt==DEB_CYCLES-1 with s=1 -> PRS, level=1, press_p=1, hcnt=0.
  - PRS: s=0 -> RDEB (held=0), dcnt=0. Otherwise hcnt++. When hcnt==HOLD_CYCLES-1 -> HLD, hold_p=1, rcnt=0.
  - HLD: s=0 -> RDEB (held=1), dcnt=0. Otherwise, if REPEAT_EN, rcnt++; when rcnt==REPEAT_CYCLES-1, repeat_p=1 and rcnt=0.
  - RDEB: hcnt/rcnt frozen. s=1 -> return to PRS or HLD per held. When dcnt==DEB_CYCLES-1 with s=0 -> REL, level=0, release_p=1.
- event_cnt adds popcount(press_p) each cycle, wraps 255->0 silently. Simultaneous presses on k channels add k in one cycle.
- Counter widths are $clog2(param+1). Counters never exceed their terminal value.
- Reset mid-operation: every FSM returns to REL, all outputs 0, event_cnt 0. No release pulse is emitted.

## Timing
- Reset values: level=0, all pulses 0, event_cnt=0.
- Press latency: with the pin stable from edge 0 (first edge sampling the asserted pin), press_p is high in cycle SYNC_STAGES+DEB_CYCLES. level rises in the same cycle.
- Release latency has the same form and the same value.
- hold_p occurs HOLD_CYCLES cycles after press_p, counting only cycles spent in PRS. The first repeat_p occurs REPEAT_CYCLES cycles after hold_p, excluding RDEB cycles.
- At most one of press_p/release_p/hold_p/repeat_p is high per channel per cycle.
- event_cnt updates one cycle after press_p (registered).
- All outputs are registered, with no combinational path from in_raw.

## Structure
- Package input_cond_pkg holds the channel state enum (REL, PDEB, PRS, HLD, RDEB) and a width helper (clog2 of param+1).
- Sub-module input_cond_ch implements the sync chain, FSM and counters for one channel. The top generates it CH times and owns the popcount adder and event_cnt.

## Test plan
All scenarios use CH=2, SYNC_STAGES=2, DEB_CYCLES=4, HOLD_CYCLES=10, REPEAT_CYCLES=3, ACTIVE_LOW=2'b11, REPEAT_EN=2'b10.
- Drive in_raw[0] low from edge 0 and hold -> press_p[0] in cycle 6, level[0]=1 from cycle 6, event_cnt=1 at cycle 7; hold_p[0] 10 cycles later; no repeat_p[0].
- Drive a 3-cycle low glitch on in_raw[0] -> no pulses, level stays 0, event_cnt stays 0.
- Hold channel 1 pressed for 30 cycles after press -> hold_p[1] at +10, then repeat_p[1] at +13, +16, +19...; releasing gives release_p[1] 6 cycles after the pin rises.
- Press both channels on the same edge -> press_p=2'b11 in one cycle, event_cnt increments by 2.
- Apply 257 clean presses on channel 0 -> event_cnt reads 1 (wrap).
- Assert reset while channel 0 is in HLD -> level=0, event_cnt=0, no release_p; after reset, with the pin still low, press_p[0] fires 6 cycles after reset deassert.
